// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith ops plus an iterative shift-add MUL.
// Define ALU_SEQ_RADIX4_EN to retire two multiplier bits per edge instead of one.
module alu_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              valid_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag
);

  localparam int SHIFT_W = $clog2(DATA_W);
`ifdef ALU_SEQ_RADIX4_EN
  localparam int STEP  = 2;
`else
  localparam int STEP  = 1;
`endif
  localparam int ITERS = DATA_W / STEP;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_out_q, alu_out_d;
  logic                zero_q, zero_d;
  logic                valid_q, valid_d;
`ifdef ALU_SEQ_RADIX4_EN
  logic [DATA_W-1:0]   mcand3_q, mcand3_d;
`endif

  logic                accept;
  logic                is_mul;
  logic [DATA_W-1:0]   op_result;
  logic [DATA_W-1:0]   partial;
  logic [DATA_W-1:0]   acc_sum;

  assign accept = valid_in && (state_q == IDLE);
  assign is_mul = (alu_control == OP_MUL);

  // Undefined codes (and MUL, which never takes this path) fall through to zero.
  always_comb begin
    op_result = '0;
    case (alu_control)
      OP_AND:  op_result = alu_in_0 & alu_in_1;
      OP_OR:   op_result = alu_in_0 | alu_in_1;
      OP_ADD:  op_result = alu_in_0 + alu_in_1;
      OP_SUB:  op_result = alu_in_0 - alu_in_1;
      OP_SLL:  op_result = alu_in_0 << alu_in_1[SHIFT_W-1:0];
      OP_SRL:  op_result = alu_in_0 >> alu_in_1[SHIFT_W-1:0];
      OP_SLT:  op_result = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      default: op_result = '0;
    endcase
  end

  always_comb begin
    partial = '0;
`ifdef ALU_SEQ_RADIX4_EN
    case (mplier_q[1:0])
      2'd1:    partial = mcand_q;
      2'd2:    partial = mcand_q << 1;
      2'd3:    partial = mcand3_q;
      default: partial = '0;
    endcase
`else
    if (mplier_q[0]) partial = mcand_q;
`endif
    acc_sum = acc_q + partial;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt_q == LAST_CNT) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
`ifdef ALU_SEQ_RADIX4_EN
    mcand3_d  = mcand3_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d  = alu_in_0;
            mplier_d = alu_in_1;
            acc_d    = '0;
            cnt_d    = '0;
`ifdef ALU_SEQ_RADIX4_EN
            mcand3_d = alu_in_0 + (alu_in_0 << 1);
`endif
          end else begin
            alu_out_d = op_result;
            zero_d    = (op_result == '0);
            valid_d   = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_SEQ_RADIX4_EN
        mcand3_d = mcand3_q << STEP;
`endif
        // The final iteration's sum goes straight to the output register.
        if (cnt_q == LAST_CNT) begin
          alu_out_d = acc_sum;
          zero_d    = (acc_sum == '0);
          valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef ALU_SEQ_RADIX4_EN
      mcand3_q  <= '0;
`endif
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
`ifdef ALU_SEQ_RADIX4_EN
      mcand3_q  <= mcand3_d;
`endif
    end
  end

  always_comb begin
    ready_in  = (state_q == IDLE);
    valid_out = valid_q;
    alu_out   = alu_out_q;
    zero_flag = zero_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expected results.
module tb_alu_seq;

`ifdef ALU_SEQ_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [3:0]  alu_control;
  logic [31:0] alu_in_0;
  logic [31:0] alu_in_1;
  logic        valid_out;
  logic [31:0] alu_out;
  logic        zero_flag;

  int tests;
  int failed;

  alu_seq #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .alu_control (alu_control),
    .alu_in_0    (alu_in_0),
    .alu_in_1    (alu_in_1),
    .valid_out   (valid_out),
    .alu_out     (alu_out),
    .zero_flag   (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so outputs are settled when sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b);
    valid_in    = v;
    alu_control = ctrl;
    alu_in_0    = a;
    alu_in_1    = b;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid,
                             input logic [31:0] exp_out, input logic exp_zero);
    checkValue({tag, "_valid"}, {31'd0, valid_out}, {31'd0, exp_valid});
    checkValue({tag, "_out"}, alu_out, exp_out);
    checkValue({tag, "_zero"}, {31'd0, zero_flag}, {31'd0, exp_zero});
  endtask

  // Issues a MUL, then waits (bounded) for its valid_out and checks latency and result.
  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_zero);
    int cycles;
    applyStimulus(1'b1, 4'd8, a, b);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    cycles = 0;
    for (int i = 0; i < LAT + 8; i++) begin
      tick();
      cycles++;
      if (valid_out) break;
    end
    checkValue({tag, "_lat"}, cycles, LAT);
    checkOutput(tag, 1'b1, exp_out, exp_zero);
  endtask

  initial begin
    int early_pulses;
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset", 1'b0, 32'd0, 1'b0);
    checkValue("reset_ready", {31'd0, ready_in}, 32'd1);

    // Back-to-back single-cycle ops
    applyStimulus(1'b1, 4'd2, 32'd5, 32'd7);
    tick();
    checkOutput("add", 1'b1, 32'd12, 1'b0);
    applyStimulus(1'b1, 4'd6, 32'd3, 32'd5);
    tick();
    checkOutput("sub", 1'b1, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
    tick();
    checkOutput("slt_neg", 1'b1, 32'd1, 1'b0);
    applyStimulus(1'b1, 4'd4, 32'h8000_0000, 32'd31);
    tick();
    checkOutput("srl", 1'b1, 32'd1, 1'b0);
    applyStimulus(1'b1, 4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    checkOutput("and", 1'b1, 32'h0000_F000, 1'b0);
    applyStimulus(1'b1, 4'd1, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    checkOutput("or", 1'b1, 32'h0000_FFF0, 1'b0);
    applyStimulus(1'b1, 4'd3, 32'd1, 32'd36);
    tick();
    checkOutput("sll_mod", 1'b1, 32'd16, 1'b0);
    applyStimulus(1'b1, 4'd7, 32'd1, 32'hFFFF_FFFF);
    tick();
    checkOutput("slt_pos", 1'b1, 32'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checkOutput("hold", 1'b0, 32'd0, 1'b1);

    // MUL with a held ADD request and operand changes during the busy span
    applyStimulus(1'b1, 4'd8, 32'h0001_0003, 32'h0000_0007);
    tick();
    checkValue("mul_ready_e0", {31'd0, ready_in}, 32'd0);
    applyStimulus(1'b1, 4'd2, 32'd100, 32'd23);
    early_pulses = 0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      if (valid_out || ready_in) early_pulses++;
    end
    checkValue("mul_busy_quiet", early_pulses, 0);
    tick();
    checkOutput("mul_basic", 1'b1, 32'h0007_0015, 1'b0);
    checkValue("mul_ready_done", {31'd0, ready_in}, 32'd1);
    tick();
    checkOutput("held_add", 1'b1, 32'd123, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checkValue("after_add_valid", {31'd0, valid_out}, 32'd0);

    runMul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    runMul("mul_wrap", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
    tick();
    checkValue("mul_single_pulse", {31'd0, valid_out}, 32'd0);

    // Reset in the middle of a MUL aborts it silently
    applyStimulus(1'b1, 4'd8, 32'd3, 32'd5);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort", 1'b0, 32'd0, 1'b0);
    checkValue("abort_ready", {31'd0, ready_in}, 32'd1);
    early_pulses = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      tick();
      if (valid_out) early_pulses++;
    end
    checkValue("abort_no_valid", early_pulses, 0);

    // Undefined opcode yields zero result
    applyStimulus(1'b1, 4'd9, 32'h0000_FFFF, 32'h0000_FFFF);
    tick();
    checkOutput("undef", 1'b1, 32'd0, 1'b1);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checkValue("undef_pulse", {31'd0, valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
